// File: rtl/seg_pkg.sv
// Shared constants and types for 7-segment display blocks.
// Segment codes are active-high, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

   localparam int SEG_W = 7;
   localparam int DIG_N = 4;

   typedef logic [1:0] dig_idx_t;

   // Entry k is the pattern for hex digit k (lowercase glyphs for b and d).
   localparam logic [15:0][SEG_W-1:0] SEG_CODES = {
      7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
      7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
      7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
      7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
   };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load handshake, display controls and pin outputs of the scan controller.
// Handshake: a load happens on a rising clk edge where value_valid && value_ready; valid while not ready is dropped.
interface seg_scan_ctrl_if;
   import seg_pkg::*;

   logic [15:0]      value;
   logic             value_valid;
   logic             value_ready;
   logic             lz_en;
   logic             blank;
   logic [SEG_W-1:0] seg;
   logic [DIG_N-1:0] dig_en;
   logic             frame_done;

   modport master (
      output value, value_valid, lz_en, blank,
      input  value_ready, seg, dig_en, frame_done
   );

   modport slave (
      input  value, value_valid, lz_en, blank,
      output value_ready, seg, dig_en, frame_done
   );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to 7-segment pattern decoder.
module hex_to_seg7
   import seg_pkg::*;
(
   input  logic [3:0]       nibble_i,
   output logic [SEG_W-1:0] seg_o
);

   assign seg_o = SEG_CODES[nibble_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 4-digit scan controller: frame-aligned value commit, per-slot
// ghosting guard, leading-zero suppression and blanking, all on registered outputs.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   seg_scan_ctrl_if.slave   bus
);

   localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   dig_idx_t         idx_q, idx_d;
   logic [15:0]      disp_q, disp_d;
   logic [15:0]      pend_q, pend_d;
   logic             pend_vld_q, pend_vld_d;
   logic [SEG_W-1:0] seg_q, seg_d;
   logic [DIG_N-1:0] dig_q, dig_d;

   logic             slot_end;
   logic             boundary;
   logic             accept;
   logic             in_guard;
   logic             lz_dark;
   logic             show;
   logic [3:0]       nib;
   logic [SEG_W-1:0] dec_seg;

   assign slot_end = (cnt_q == LAST_C);
   assign boundary = slot_end && (idx_q == 2'd3);
   assign accept   = bus.value_valid && !pend_vld_q;

   if (BLANK_CYCLES == 0) begin : g_noguard
      assign in_guard = 1'b0;
   end else begin : g_guard
      assign in_guard = (cnt_q < BLANK_C);
   end

   always_comb begin
      nib     = 4'd0;
      lz_dark = 1'b0;
      case (idx_q)
         2'd0: begin
            nib     = disp_q[3:0];
            lz_dark = 1'b0;
         end
         2'd1: begin
            nib     = disp_q[7:4];
            lz_dark = (disp_q[15:4] == 12'd0);
         end
         2'd2: begin
            nib     = disp_q[11:8];
            lz_dark = (disp_q[15:8] == 8'd0);
         end
         default: begin
            nib     = disp_q[15:12];
            lz_dark = (disp_q[15:12] == 4'd0);
         end
      endcase
   end

   hex_to_seg7 u_dec (
      .nibble_i (nib),
      .seg_o    (dec_seg)
   );

   assign show = !bus.blank && !in_guard && !(bus.lz_en && lz_dark);

   always_comb begin
      cnt_d      = slot_end ? '0 : cnt_q + 1'b1;
      idx_d      = slot_end ? idx_q + 2'd1 : idx_q;
      disp_d     = disp_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      seg_d      = '0;
      dig_d      = '0;

      // Commit and accept are exclusive: accept needs the flag clear, commit needs it set,
      // so a value accepted in the boundary cycle waits for the next frame.
      if (boundary && pend_vld_q) begin
         disp_d     = pend_q;
         pend_vld_d = 1'b0;
      end
      if (accept) begin
         pend_d     = bus.value;
         pend_vld_d = 1'b1;
      end

      if (show) begin
         seg_d = dec_seg;
         dig_d = DIG_N'(1) << idx_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         idx_q      <= '0;
         disp_q     <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         seg_q      <= '0;
         dig_q      <= '0;
      end else begin
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         disp_q     <= disp_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         seg_q      <= seg_d;
         dig_q      <= dig_d;
      end
   end

   assign bus.value_ready = !pend_vld_q;
   assign bus.frame_done  = boundary;
   assign bus.seg         = seg_q;
   assign bus.dig_en      = dig_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed and randomized bench for seg_scan_ctrl with SCAN_DIV=8, BLANK_CYCLES=2.
module tb_seg_scan_ctrl;

   localparam int SCAN_DIV = 8;
   localparam int BLANK    = 2;
   localparam int FRAME    = 4 * SCAN_DIV;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   seg_scan_ctrl_if bus ();

   seg_scan_ctrl #(
      .SCAN_DIV     (SCAN_DIV),
      .BLANK_CYCLES (BLANK),
      .CNT_W        (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   logic [10:0] exp_q[$];

   logic [6:0] code_tab [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   // Reference model: time since reset fixes slot and digit by division.
   int          m_t;
   logic [15:0] m_disp;
   logic [15:0] m_pend;
   logic        m_pflag;
   logic [6:0]  m_seg;
   logic [3:0]  m_dig;

   function automatic bit m_boundary();
      return ((m_t % SCAN_DIV) == SCAN_DIV - 1) && (((m_t / SCAN_DIV) % 4) == 3);
   endfunction

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s t=%0d: observed %h expected %h", tag, m_t, got, exp);
      end
   endtask

   task automatic model_edge();
      int cnt;
      int idx;
      bit acc;
      if (!rst_n) begin
         m_t = 0; m_disp = '0; m_pend = '0; m_pflag = 1'b0; m_seg = '0; m_dig = '0;
         return;
      end
      cnt = m_t % SCAN_DIV;
      idx = (m_t / SCAN_DIV) % 4;
      if (bus.blank || cnt < BLANK || (bus.lz_en && idx > 0 && (m_disp >> (4 * idx)) == 16'd0)) begin
         m_seg = '0;
         m_dig = '0;
      end else begin
         m_seg = code_tab[m_disp[4*idx +: 4]];
         m_dig = 4'(1 << idx);
      end
      acc = bus.value_valid && !m_pflag;
      if (m_boundary() && m_pflag) begin
         m_disp  = m_pend;
         m_pflag = 1'b0;
      end
      if (acc) begin
         m_pend  = bus.value;
         m_pflag = 1'b1;
      end
      m_t++;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("seg", 16'(bus.seg), 16'(m_seg));
      chk("dig_en", 16'(bus.dig_en), 16'(m_dig));
      chk("value_ready", 16'(bus.value_ready), 16'(!m_pflag));
      chk("frame_done", 16'(bus.frame_done), 16'(m_boundary()));
   endtask

   task automatic load(input logic [15:0] v);
      chk("ready_at_load", 16'(bus.value_ready), 16'd1);
      bus.value       = v;
      bus.value_valid = 1'b1;
      step();
      bus.value_valid = 1'b0;
   endtask

   task automatic wait_boundary();
      int n;
      n = 0;
      while (!m_boundary() && n < FRAME + 8) begin
         step();
         n++;
      end
      if (!m_boundary()) chk("boundary_timeout", 16'd0, 16'd1);
   endtask

   // Syncs to the next boundary, then checks one {dig_en,seg} per digit at slot end.
   task automatic check_frame(input string tag);
      logic [10:0] e;
      wait_boundary();
      step();
      chk({tag, "_ready_after_commit"}, 16'(bus.value_ready), 16'd1);
      for (int d = 0; d < 4; d++) begin
         for (int k = 0; k < SCAN_DIV; k++) step();
         if (exp_q.size() == 0) begin
            chk({tag, "_exp_q_empty"}, 16'd0, 16'd1);
         end else begin
            e = exp_q.pop_front();
            chk(tag, 16'({bus.dig_en, bus.seg}), 16'(e));
         end
      end
   endtask

   int          fd_cnt;
   logic [3:0]  dig_or;
   logic [15:0] rv;

   initial begin
      bus.value       = '0;
      bus.value_valid = 1'b0;
      bus.lz_en       = 1'b0;
      bus.blank       = 1'b0;

      // Reset and idle
      rst_n = 1'b0;
      step();
      step();
      chk("rst_seg", 16'(bus.seg), 16'd0);
      chk("rst_dig", 16'(bus.dig_en), 16'd0);
      chk("rst_ready", 16'(bus.value_ready), 16'd1);
      chk("rst_fd", 16'(bus.frame_done), 16'd0);
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("idle_dig0", 16'(bus.dig_en), (k >= 3) ? 16'd1 : 16'd0);
         chk("idle_seg0", 16'(bus.seg), (k >= 3) ? 16'h3F : 16'h00);
      end
      fd_cnt = 0;
      for (int k = 0; k < 2 * FRAME; k++) begin
         step();
         if (bus.frame_done) fd_cnt++;
      end
      chk("idle_fd_count", 16'(fd_cnt), 16'd2);

      // Mid-frame load of 1A2F
      wait_boundary();
      for (int k = 0; k < 10; k++) step();
      load(16'h1A2F);
      chk("pending_not_ready", 16'(bus.value_ready), 16'd0);
      exp_q.push_back({4'b0001, 7'h71});
      exp_q.push_back({4'b0010, 7'h5B});
      exp_q.push_back({4'b0100, 7'h77});
      exp_q.push_back({4'b1000, 7'h06});
      check_frame("frame_1A2F");

      // Second request while pending is dropped
      load(16'h1234);
      bus.value       = 16'hFFFF;
      bus.value_valid = 1'b1;
      for (int k = 0; k < 3; k++) step();
      bus.value_valid = 1'b0;
      exp_q.push_back({4'b0001, 7'h66});
      exp_q.push_back({4'b0010, 7'h4F});
      exp_q.push_back({4'b0100, 7'h5B});
      exp_q.push_back({4'b1000, 7'h06});
      check_frame("frame_1234");

      // Leading-zero suppression
      bus.lz_en = 1'b1;
      load(16'h0050);
      exp_q.push_back({4'b0001, 7'h3F});
      exp_q.push_back({4'b0010, 7'h6D});
      exp_q.push_back({4'b0000, 7'h00});
      exp_q.push_back({4'b0000, 7'h00});
      check_frame("frame_lz_0050");
      load(16'h0000);
      exp_q.push_back({4'b0001, 7'h3F});
      exp_q.push_back({4'b0000, 7'h00});
      exp_q.push_back({4'b0000, 7'h00});
      exp_q.push_back({4'b0000, 7'h00});
      check_frame("frame_lz_0000");
      bus.lz_en = 1'b0;

      // Blank for one full frame
      bus.blank = 1'b1;
      fd_cnt = 0;
      dig_or = '0;
      for (int k = 0; k < FRAME; k++) begin
         step();
         dig_or |= bus.dig_en;
         if (bus.frame_done) fd_cnt++;
      end
      chk("blank_dig_or", 16'(dig_or), 16'd0);
      chk("blank_fd_count", 16'(fd_cnt), 16'd1);
      bus.blank = 1'b0;
      for (int k = 0; k < SCAN_DIV; k++) step();

      // Reset mid-slot with a pending load
      wait_boundary();
      for (int k = 0; k < 5; k++) step();
      load(16'h5555);
      for (int k = 0; k < 3; k++) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("post_rst_ready", 16'(bus.value_ready), 16'd1);
      chk("post_rst_dig", 16'(bus.dig_en), 16'd0);
      exp_q.push_back({4'b0001, 7'h3F});
      exp_q.push_back({4'b0010, 7'h3F});
      exp_q.push_back({4'b0100, 7'h3F});
      exp_q.push_back({4'b1000, 7'h3F});
      check_frame("frame_after_rst");

      // Randomized traffic against the model
      for (int k = 0; k < 600; k++) begin
         rv = 16'($urandom);
         bus.value       = rv >> (4 * $urandom_range(0, 4));
         bus.value_valid = ($urandom_range(0, 5) == 0);
         bus.blank       = ($urandom_range(0, 15) == 0);
         if ((k % 64) == 0) bus.lz_en = 1'($urandom_range(0, 1));
         step();
      end
      bus.value_valid = 1'b0;
      bus.blank       = 1'b0;

      chk("exp_q_drained", 16'(exp_q.size()), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
